// File: rtl/oam_sprite_if.sv
// oam_sprite_if: CPU, DMA, evaluation and secondary-read signals of the OAM sprite unit
interface oam_sprite_if;
   logic       cpu_oamaddr_wren;
   logic       cpu_oamdata_wren;
   logic       cpu_oamdata_rden;
   logic [7:0] cpu_data_in;
   logic [7:0] cpu_data_out;
   logic       dma_write;
   logic [7:0] dma_address;
   logic [7:0] dma_data;
   logic       eval_start;
   logic [7:0] eval_scanline;
   logic       sprite_height_16;
   logic       eval_busy;
   logic       eval_done;
   logic [3:0] sprite_count;
   logic       sprite_overflow;
   logic       sprite0_in_range;
   logic [4:0] sec_oam_rd_addr;
   logic [7:0] sec_oam_rd_data;
   modport master (
      output cpu_oamaddr_wren, cpu_oamdata_wren, cpu_oamdata_rden, cpu_data_in,
      output dma_write, dma_address, dma_data,
      output eval_start, eval_scanline, sprite_height_16, sec_oam_rd_addr,
      input  cpu_data_out, eval_busy, eval_done, sprite_count, sprite_overflow,
      input  sprite0_in_range, sec_oam_rd_data
   );
   modport slave (
      input  cpu_oamaddr_wren, cpu_oamdata_wren, cpu_oamdata_rden, cpu_data_in,
      input  dma_write, dma_address, dma_data,
      input  eval_start, eval_scanline, sprite_height_16, sec_oam_rd_addr,
      output cpu_data_out, eval_busy, eval_done, sprite_count, sprite_overflow,
      output sprite0_in_range, sec_oam_rd_data
   );
endinterface

// File: rtl/oam_sprite_unit.sv
// oam_sprite_unit: primary/secondary OAM with CPU/DMA access and per-scanline sprite evaluation
module oam_sprite_unit #(
   parameter int MAX_SPRITES = 8
) (
   input logic clk,
   input logic reset,
   oam_sprite_if.slave bus
);
   localparam int SEC_BYTES = 4 * MAX_SPRITES;
   typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;
   state_t     state;
   logic [7:0] prim [256];
   logic [7:0] sec [SEC_BYTES];
   logic [7:0] oam_addr, scanline, cpu_rd, sec_rd, cur;
   logic       tall, busy, done, overflow, sprite0, stall, in_range, last;
   logic [5:0] n;
   logic [1:0] k;
   logic [3:0] count;
   logic [8:0] diff;
   assign bus.cpu_data_out     = cpu_rd;
   assign bus.eval_busy        = busy;
   assign bus.eval_done        = done;
   assign bus.sprite_count     = count;
   assign bus.sprite_overflow  = overflow;
   assign bus.sprite0_in_range = sprite0;
   assign bus.sec_oam_rd_data  = sec_rd;
   // n doubles as the clear index; in SCAN, k=0 is the Y-check cycle and k=1..3 copy bytes
   always_comb begin
      cur      = prim[{n, k}];
      diff     = {1'b0, scanline} - {1'b0, cur};
      in_range = !diff[8] && diff[7:0] < (tall ? 8'd16 : 8'd8);
      stall    = bus.dma_write && (state == CLEAR || state == SCAN);
      last     = n == 6'd63;
   end
   always_ff @(posedge clk) begin
      if (bus.dma_write)
         prim[oam_addr + bus.dma_address] <= bus.dma_data;
      else if (bus.cpu_oamdata_wren && !busy)
         prim[oam_addr] <= bus.cpu_data_in;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         oam_addr <= 8'd0;
         cpu_rd   <= 8'd0;
      end else begin
         if (bus.cpu_oamaddr_wren)
            oam_addr <= bus.cpu_data_in;
         else if (bus.cpu_oamdata_wren && !busy && !bus.dma_write)
            oam_addr <= oam_addr + 8'd1;
         if (bus.cpu_oamdata_rden)
            cpu_rd <= prim[oam_addr] & (oam_addr[1:0] == 2'd2 ? 8'hE3 : 8'hFF);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= 4'd0;
         overflow <= 1'b0;
         sprite0  <= 1'b0;
         n        <= 6'd0;
         k        <= 2'd0;
         scanline <= 8'd0;
         tall     <= 1'b0;
         for (int i = 0; i < SEC_BYTES; i++) sec[i] <= 8'hFF;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.eval_start) begin
               scanline <= bus.eval_scanline;
               tall     <= bus.sprite_height_16;
               count    <= 4'd0;
               overflow <= 1'b0;
               sprite0  <= 1'b0;
               n        <= 6'd0;
               k        <= 2'd0;
               busy     <= 1'b1;
               state    <= CLEAR;
            end
            CLEAR: if (!stall) begin
               sec[n[4:0]] <= 8'hFF;
               n <= n == 6'd31 ? 6'd0 : n + 6'd1;
               if (n == 6'd31) state <= SCAN;
            end
            SCAN: if (!stall) begin
               if (k == 2'd0 && in_range && count[3]) begin
                  overflow <= 1'b1;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if (k == 2'd0 && !in_range) begin
                  n <= n + 6'd1;
                  if (last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else begin
                  sec[{count[2:0], k}] <= cur;
                  k <= k + 2'd1;
                  if (k == 2'd3) begin
                     count   <= count + 4'd1;
                     sprite0 <= sprite0 | (n == 6'd0);
                     n       <= n + 6'd1;
                     if (last) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) sec_rd <= 8'hFF;
      else sec_rd <= sec[bus.sec_oam_rd_addr];
   end
endmodule

// File: tb/tb_oam_sprite_unit.sv
// tb_oam_sprite_unit: scoreboard bench for CPU/DMA OAM access and sprite evaluation
module tb_oam_sprite_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   oam_sprite_if bus();
   oam_sprite_unit dut (.clk(clk), .reset(reset), .bus(bus));
   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] pm [256];
   logic [7:0] img [256];
   logic [7:0] sm [32];
   logic [7:0] m_addr = 8'd0;
   logic [7:0] exp_q [$];
   logic [5:0] ev_q [$];
   logic [7:0] e;
   logic [5:0] er, got;
   int c, c0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_addr(input logic [7:0] v);
      bus.cpu_oamaddr_wren = 1'b1;
      bus.cpu_data_in = v;
      tick;
      bus.cpu_oamaddr_wren = 1'b0;
      m_addr = v;
   endtask

   task automatic cpu_write(input logic [7:0] v);
      bus.cpu_oamdata_wren = 1'b1;
      bus.cpu_data_in = v;
      tick;
      bus.cpu_oamdata_wren = 1'b0;
      pm[m_addr] = v;
      m_addr = m_addr + 8'd1;
   endtask

   task automatic cpu_read;
      exp_q.push_back(pm[m_addr] & (m_addr[1:0] == 2'd2 ? 8'hE3 : 8'hFF));
      bus.cpu_oamdata_rden = 1'b1;
      tick;
      bus.cpu_oamdata_rden = 1'b0;
   endtask

   task automatic dma(input logic [7:0] a, input logic [7:0] d);
      bus.dma_write = 1'b1;
      bus.dma_address = a;
      bus.dma_data = d;
      tick;
      bus.dma_write = 1'b0;
      pm[8'(m_addr + a)] = d;
   endtask

   task automatic sec_read(input int a);
      exp_q.push_back(sm[a]);
      bus.sec_oam_rd_addr = 5'(a);
      tick;
   endtask

   task automatic load_img;
      cpu_addr(8'd0);
      for (int i = 0; i < 256; i++) dma(8'(i), img[i]);
   endtask

   task automatic set_img(input logic [7:0] y_hit, input int first, input int last_s);
      for (int s = 0; s < 64; s++) begin
         img[4*s]   = (s >= first && s <= last_s) ? y_hit : 8'hF0;
         img[4*s+1] = 8'(s);
         img[4*s+2] = 8'(s) ^ 8'h33;
         img[4*s+3] = 8'(2 * s + 1);
      end
   endtask

   task automatic model_eval(input int sl, input bit h16, output logic [5:0] r);
      int cnt, y;
      bit ov, s0;
      cnt = 0;
      ov = 1'b0;
      s0 = 1'b0;
      for (int i = 0; i < 32; i++) sm[i] = 8'hFF;
      for (int s = 0; s < 64; s++) begin
         y = int'(pm[4*s]);
         if (sl >= y && sl - y < (h16 ? 16 : 8)) begin
            if (cnt == 8) begin
               ov = 1'b1;
               break;
            end
            for (int b = 0; b < 4; b++) sm[4*cnt+b] = pm[4*s+b];
            if (s == 0) s0 = 1'b1;
            cnt++;
         end
      end
      r = {4'(cnt), ov, s0};
   endtask

   task automatic start_eval(input int sl, input bit h16);
      logic [5:0] r;
      model_eval(sl, h16, r);
      ev_q.push_back(r);
      bus.eval_scanline = 8'(sl);
      bus.sprite_height_16 = h16;
      bus.eval_start = 1'b1;
      tick;
      bus.eval_start = 1'b0;
   endtask

   task automatic wait_done(input bit inj, output int cyc);
      logic [7:0] a;
      cyc = 0;
      while (bus.eval_done !== 1'b1 && cyc < 200) begin
         if (inj && cyc >= 40 && cyc < 50) begin
            a = 8'(cyc + 150);
            bus.dma_address = a;
            bus.dma_data = pm[8'(m_addr + a)];
            bus.dma_write = 1'b1;
         end else bus.dma_write = 1'b0;
         tick;
         cyc++;
      end
      bus.dma_write = 1'b0;
   endtask

   task automatic test_reset;
      n_checks += 7;
      if (bus.cpu_data_out !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_data: got %h exp 00", bus.cpu_data_out); end
      if (bus.eval_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.eval_busy); end
      if (bus.eval_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", bus.eval_done); end
      if (bus.sprite_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", bus.sprite_count); end
      if (bus.sprite_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b exp 0", bus.sprite_overflow); end
      if (bus.sprite0_in_range !== 1'b0) begin n_fail++; $display("FAIL rst_s0: got %b exp 0", bus.sprite0_in_range); end
      if (bus.sec_oam_rd_data !== 8'hFF) begin n_fail++; $display("FAIL rst_sec_data: got %h exp FF", bus.sec_oam_rd_data); end
   endtask

   task automatic test_cpu_access;
      cpu_addr(8'd0);
      for (int i = 0; i < 256; i++) dma(8'(i), 8'(i) ^ 8'h5A);
      cpu_addr(8'd10);
      cpu_write(8'hAA);
      cpu_write(8'hBB);
      cpu_write(8'hCC);
      for (int i = 0; i < 5; i++) begin
         if (i >= 2) cpu_addr(8'(8 + i));
         cpu_read;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.cpu_data_out !== e) begin n_fail++; $display("FAIL cpu_rd%0d: got %h exp %h", i, bus.cpu_data_out, e); end
      end
   endtask

   task automatic test_addr_wrap;
      cpu_addr(8'hFF);
      cpu_write(8'h11);
      cpu_write(8'h22);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) cpu_addr(8'hFF);
         if (i == 2) cpu_addr(8'h00);
         cpu_read;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.cpu_data_out !== e) begin n_fail++; $display("FAIL wrap_rd%0d: got %h exp %h", i, bus.cpu_data_out, e); end
      end
   endtask

   task automatic test_dma;
      cpu_addr(8'h04);
      for (int i = 0; i < 256; i++) dma(8'(i), 8'(i));
      for (int i = 0; i < 2; i++) begin
         if (i == 1) cpu_addr(8'h02);
         cpu_read;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.cpu_data_out !== e) begin n_fail++; $display("FAIL dma_rd%0d: got %h exp %h", i, bus.cpu_data_out, e); end
      end
      n_checks++;
      if (bus.cpu_data_out !== 8'hE2) begin n_fail++; $display("FAIL attr_mask: got %h exp E2", bus.cpu_data_out); end
      cpu_addr(8'h40);
      bus.cpu_oamdata_wren = 1'b1;
      bus.cpu_data_in = 8'h99;
      dma(8'd1, 8'h77);
      bus.cpu_oamdata_wren = 1'b0;
      bus.cpu_oamaddr_wren = 1'b1;
      bus.cpu_data_in = 8'h80;
      dma(8'd2, 8'h66);
      bus.cpu_oamaddr_wren = 1'b0;
      m_addr = 8'h80;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) cpu_addr(8'h40);
         if (i == 2) cpu_addr(8'h41);
         if (i == 3) cpu_addr(8'h43);
         cpu_read;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.cpu_data_out !== e) begin n_fail++; $display("FAIL dma_prio_rd%0d: got %h exp %h", i, bus.cpu_data_out, e); end
      end
   endtask

   task automatic test_eval_basic;
      set_img(8'd20, 99, 99);
      img[0] = 8'd20;
      img[12] = 8'd20;
      img[20] = 8'd20;
      load_img;
      start_eval(25, 1'b0);
      wait_done(1'b0, c);
      er = ev_q.pop_front();
      got = {bus.sprite_count, bus.sprite_overflow, bus.sprite0_in_range};
      n_checks += 2;
      if (c > 122) begin n_fail++; $display("FAIL basic_latency: got %0d cycles exp <= 122", c); end
      if (got !== er) begin n_fail++; $display("FAIL basic_result: got %h exp %h", got, er); end
      tick;
      n_checks += 2;
      if (bus.eval_done !== 1'b0 || bus.eval_busy !== 1'b0) begin n_fail++; $display("FAIL basic_end: got done=%b busy=%b exp 0/0", bus.eval_done, bus.eval_busy); end
      if (bus.sprite_count !== 4'd3) begin n_fail++; $display("FAIL basic_hold: got %0d exp 3", bus.sprite_count); end
      for (int i = 0; i < 32; i++) begin
         sec_read(i);
         e = exp_q.pop_front();
         n_checks++;
         if (bus.sec_oam_rd_data !== e) begin n_fail++; $display("FAIL basic_sec%0d: got %h exp %h", i, bus.sec_oam_rd_data, e); end
      end
   endtask

   task automatic test_busy_write;
      start_eval(25, 1'b0);
      n_checks++;
      if (bus.eval_busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag: got %b exp 1", bus.eval_busy); end
      bus.cpu_oamdata_wren = 1'b1;
      bus.cpu_data_in = 8'h5C;
      tick;
      bus.cpu_oamdata_wren = 1'b0;
      wait_done(1'b0, c);
      er = ev_q.pop_front();
      got = {bus.sprite_count, bus.sprite_overflow, bus.sprite0_in_range};
      n_checks += 2;
      if (c >= 200) begin n_fail++; $display("FAIL busy_timeout: got %0d cycles exp < 200", c); end
      if (got !== er) begin n_fail++; $display("FAIL busy_result: got %h exp %h", got, er); end
      for (int i = 0; i < 2; i++) begin
         if (i == 1) cpu_addr(8'h01);
         cpu_read;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.cpu_data_out !== e) begin n_fail++; $display("FAIL busy_wr_rd%0d: got %h exp %h", i, bus.cpu_data_out, e); end
      end
      cpu_addr(8'h00);
   endtask

   task automatic test_overflow;
      int sl [3] = '{107, 108, 108};
      bit h [3] = '{1'b0, 1'b0, 1'b1};
      logic [5:0] lit [3] = '{{4'd8, 2'b11}, 6'd0, {4'd8, 2'b11}};
      set_img(8'd100, 0, 9);
      load_img;
      for (int t = 0; t < 3; t++) begin
         start_eval(sl[t], h[t]);
         wait_done(1'b0, c);
         er = ev_q.pop_front();
         got = {bus.sprite_count, bus.sprite_overflow, bus.sprite0_in_range};
         n_checks += 3;
         if (c >= 200) begin n_fail++; $display("FAIL ovf_timeout%0d: got %0d cycles exp < 200", t, c); end
         if (got !== er) begin n_fail++; $display("FAIL ovf_result%0d: got %h exp %h", t, got, er); end
         if (got !== lit[t]) begin n_fail++; $display("FAIL ovf_const%0d: got %h exp %h", t, got, lit[t]); end
         tick;
         if (t == 1) for (int i = 0; i < 32; i++) begin
            sec_read(i);
            e = exp_q.pop_front();
            n_checks++;
            if (bus.sec_oam_rd_data !== e) begin n_fail++; $display("FAIL ovf_sec%0d: got %h exp %h", i, bus.sec_oam_rd_data, e); end
         end
      end
   endtask

   task automatic test_dma_stall;
      start_eval(110, 1'b1);
      wait_done(1'b0, c0);
      er = ev_q.pop_front();
      tick;
      start_eval(110, 1'b1);
      wait_done(1'b1, c);
      er = ev_q.pop_front();
      got = {bus.sprite_count, bus.sprite_overflow, bus.sprite0_in_range};
      n_checks += 2;
      if (c !== c0 + 10) begin n_fail++; $display("FAIL stall_latency: got %0d cycles exp %0d", c, c0 + 10); end
      if (got !== er) begin n_fail++; $display("FAIL stall_result: got %h exp %h", got, er); end
      tick;
      for (int i = 0; i < 32; i++) begin
         sec_read(i);
         e = exp_q.pop_front();
         n_checks++;
         if (bus.sec_oam_rd_data !== e) begin n_fail++; $display("FAIL stall_sec%0d: got %h exp %h", i, bus.sec_oam_rd_data, e); end
      end
   endtask

   task automatic test_reset_mid;
      start_eval(107, 1'b0);
      repeat (45) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      ev_q.delete();
      m_addr = 8'd0;
      for (int i = 0; i < 32; i++) sm[i] = 8'hFF;
      test_reset;
      for (int i = 0; i < 32; i++) begin
         sec_read(i);
         e = exp_q.pop_front();
         n_checks++;
         if (bus.sec_oam_rd_data !== e) begin n_fail++; $display("FAIL rstmid_sec%0d: got %h exp %h", i, bus.sec_oam_rd_data, e); end
      end
      start_eval(108, 1'b1);
      wait_done(1'b0, c);
      er = ev_q.pop_front();
      got = {bus.sprite_count, bus.sprite_overflow, bus.sprite0_in_range};
      n_checks += 2;
      if (c >= 200) begin n_fail++; $display("FAIL rstmid_timeout: got %0d cycles exp < 200", c); end
      if (got !== er) begin n_fail++; $display("FAIL rstmid_result: got %h exp %h", got, er); end
   endtask

   initial begin
      bus.cpu_oamaddr_wren = 1'b0;
      bus.cpu_oamdata_wren = 1'b0;
      bus.cpu_oamdata_rden = 1'b0;
      bus.cpu_data_in = 8'd0;
      bus.dma_write = 1'b0;
      bus.dma_address = 8'd0;
      bus.dma_data = 8'd0;
      bus.eval_start = 1'b0;
      bus.eval_scanline = 8'd0;
      bus.sprite_height_16 = 1'b0;
      bus.sec_oam_rd_addr = 5'd0;
      repeat (3) tick;
      reset = 1'b0;
      test_reset;
      test_cpu_access;
      test_addr_wrap;
      test_dma;
      test_eval_basic;
      test_busy_write;
      test_overflow;
      test_dma_stall;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/oam_sprite_unit.md
Name: oam_sprite_unit

Overview:
Receiving end of the $4014 OAM DMA stream and of CPU accesses to $2003/$2004. Holds 256-byte primary OAM and 32-byte secondary OAM. Runs per-scanline sprite evaluation for the PPU renderer. Sits inside the PPU, on the PPU clock, fed by the top-level DMA engine and the CPU bus decode.

Parameters:
MAX_SPRITES, 8, secondary OAM capacity in sprites. Fixed at 8; secondary size is 4*MAX_SPRITES bytes.

Ports:
CLK  in  1  PPU clock
RESET  in  1  synchronous, active-high
CPU_OAMADDR_wren  in  1  CPU write to $2003
CPU_OAMDATA_wren  in  1  CPU write to $2004
CPU_OAMDATA_rden  in  1  CPU read of $2004
CPU_DATA_IN  in  8  CPU write data
CPU_DATA_OUT  out  8  $2004 read data
DMA_write  in  1  DMA byte strobe
DMA_address  in  8  DMA byte index 0..255
DMA_data  in  8  DMA byte
EVAL_start  in  1  one-cycle pulse that starts an evaluation
EVAL_scanline  in  8  target scanline, sampled on EVAL_start
SPRITE_HEIGHT_16  in  1  sprite height: 1 = 8x16, 0 = 8x8; sampled on EVAL_start
EVAL_busy  out  1  evaluation in progress
EVAL_done  out  1  one-cycle completion pulse
SPRITE_COUNT  out  4  sprites found, 0..8
SPRITE_OVERFLOW  out  1  more than 8 sprites in range
SPRITE0_IN_RANGE  out  1  OAM sprite 0 is among those found
SEC_OAM_rd_addr  in  5  renderer read address into secondary OAM
SEC_OAM_rd_data  out  8  secondary OAM data, registered

Behaviour:
- Reset: oam_addr=0; CPU_DATA_OUT=0; EVAL_busy=0; EVAL_done=0; SPRITE_COUNT=0; SPRITE_OVERFLOW=0; SPRITE0_IN_RANGE=0; SEC_OAM_rd_data=FF; all secondary bytes=FF; FSM=IDLE. Primary OAM contents are not reset.
- Reset during an evaluation aborts it immediately with the same values as above.
- $2003 write: oam_addr <= CPU_DATA_IN.
- $2004 write, not busy:
  - primary[oam_addr] <= data.
  - oam_addr <= oam_addr+1, wrapping mod 256.
- $2004 write while EVAL_busy: ignored entirely, including the increment.
- $2004 read:
  - CPU_DATA_OUT <= primary[oam_addr] on the next cycle; held until the next read.
  - No address increment.
  - If oam_addr[1:0]==2 (attribute byte), bits 4:2 read as 0 (mask E3).
- DMA_write:
  - primary[(oam_addr+DMA_address) mod 256] <= DMA_data.
  - oam_addr is unchanged.
  - DMA has priority over a same-cycle $2004 write; the CPU write is dropped, including its increment.
  - A same-cycle $2003 write is still applied.
- Secondary read: SEC_OAM_rd_data <= sec[SEC_OAM_rd_addr], 1-cycle latency, valid in every state.
- FSM states: IDLE -> CLEAR -> SCAN -> DONE -> IDLE.
- IDLE:
  - EVAL_start latches scanline and height, clears COUNT, OVERFLOW and SPRITE0, then goes to CLEAR.
  - EVAL_start while not IDLE is ignored.
- CLEAR: 32 cycles, one secondary byte set to FF per cycle, index 0..31.
- SCAN: n = sprite index 0..63.
  - Y-check cycle: read primary[4n]. In range iff EVAL_scanline >= Y and (EVAL_scanline-Y) < height (8 or 16). Compute in 9 bits; no wrap.
  - In range and count<8: write Y to sec[4*count], then 3 copy cycles for bytes 1..3.
  - After the copy: count+1; SPRITE0_IN_RANGE=1 if n==0.
  - In range and count==8: SPRITE_OVERFLOW=1, go to DONE (early exit).
  - Not in range: 1 cycle only, then next n.
  - After n=63, go to DONE.
- DONE: EVAL_done=1 for exactly 1 cycle, then IDLE.
- EVAL_busy=1 in CLEAR, SCAN and DONE. Results are held until the next EVAL_start.
- DMA_write during CLEAR or SCAN stalls the FSM for that cycle: no state, index or secondary change.
- Worst case without stalls: 1 + 32 + 64 + 24 + 1 = 122 cycles from EVAL_start to EVAL_done.

Test Plan:
1. $2003=10, $2004 writes AA, BB, CC -> primary[10..12]=AA/BB/CC; oam_addr=13; $2004 read returns primary[13]; a second read shows no increment.
2. $2003=FF, writes 11, 22 -> primary[FF]=11, primary[00]=22, oam_addr=01.
3. $2003=04, then 256 DMA writes with data=index -> primary[(4+i)&FF]=i; oam_addr stays 04. $2003=02, read -> FE&E3=E2.
4. Sprites 0, 3, 5 with Y=20 and all others Y=F0; scanline 25, 8x8 -> COUNT=3, SPRITE0=1, OVERFLOW=0; sec[0..3]=sprite 0 bytes; sec[12..31]=FF; EVAL_done within 122 cycles.
5. Sprites 0..9 with Y=100:
   - scanline 107, 8x8 -> COUNT=8, OVERFLOW=1.
   - scanline 108, 8x8 -> COUNT=0, OVERFLOW=0.
   - scanline 108, 8x16 -> COUNT=8, OVERFLOW=1.
6. Evaluation with 10 DMA_write pulses injected mid-SCAN -> same results, EVAL_done 10 cycles late. RESET asserted mid-SCAN -> all outputs at reset values, sec all FF, a later EVAL_start behaves normally.
